// File: rtl/booth_mult8.sv
// booth_mult8: sequential signed WIDTHxWIDTH multiplier, radix-2 Booth recoding.
// One Booth iteration per clock. The operand capture is folded into the
// IDLE->RUN transition, so there is no separate LOAD state.
// Optional feature: define BOOTH_MULT8_OVF_EN to flag products that do not fit
// in signed WIDTH bits. Without it, ovf is tied to 0.
//
// state | meaning
// IDLE  | waiting for start; operands captured on the accepting edge
// RUN   | one Booth add/sub plus arithmetic shift per cycle, WIDTH cycles
// DONE  | product, ovf and the one-cycle done pulse are registered
module booth_mult8 #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a_in,
  input  logic [WIDTH-1:0]     b_in,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product,
  output logic                 ovf
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state;
  logic [WIDTH:0]     acc;
  logic [WIDTH:0]     m;
  logic [WIDTH-1:0]   q;
  logic               q_1;
  logic [CW-1:0]      count;
  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] product_next;

  assign product_next = {acc[WIDTH-1:0], q};

  // Booth recoding of the current multiplier bit pair: add, subtract or pass
  always_comb begin
    sum = acc;
    case ({q[0], q_1})
      2'b01:   sum = acc + m;
      2'b10:   sum = acc - m;
      default: sum = acc;
    endcase
  end

`ifdef BOOTH_MULT8_OVF_EN
  logic [WIDTH:0] top_bits;
  logic           ovf_next;

  assign top_bits = product_next[2*WIDTH-1:WIDTH-1];
  assign ovf_next = ~((&top_bits) | ~(|top_bits));
`else
  assign ovf = 1'b0;
`endif

  // Control FSM and datapath registers; results change only in DONE
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      acc     <= '0;
      m       <= '0;
      q       <= '0;
      q_1     <= 1'b0;
      count   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
`ifdef BOOTH_MULT8_OVF_EN
      ovf     <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            m     <= {a_in[WIDTH-1], a_in};
            q     <= b_in;
            acc   <= '0;
            q_1   <= 1'b0;
            count <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          acc   <= {sum[WIDTH], sum[WIDTH:1]};
          q     <= {sum[0], q[WIDTH-1:1]};
          q_1   <= q[0];
          count <= count + CW'(1);
          if (count == LAST) begin
            busy  <= 1'b0;
            state <= DONE;
          end
        end
        DONE: begin
          product <= product_next;
`ifdef BOOTH_MULT8_OVF_EN
          ovf     <= ovf_next;
`endif
          done    <= 1'b1;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
